// File: rtl/ascon_perm_sched.sv
// Round scheduler for the Ascon permutation: sequences load, p12/p6 rounds and done.
// Optional cancel port abort_i is enabled by defining ASCON_ABORT_EN.
module ascon_perm_sched (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       nrounds_i,
`ifdef ASCON_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       load_o,
  output logic       perm_en_o,
  output logic [3:0] round_o,
  output logic       last_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(11);
  localparam logic [CNT_W-1:0] P6_START   = CNT_W'(6);
  localparam logic [CNT_W-1:0] P12_START  = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nr;
  logic             r_load;
  logic             r_perm_en;
  logic             r_last;
  logic             r_busy;
  logic             r_done;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_nr;
  logic             w_abort;

`ifdef ASCON_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Next-state and next-counter logic; abort only cancels LOAD/ROUND, never IDLE start
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_nr    = r_nr;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state = ST_LOAD;
          w_nr    = nrounds_i;
          w_cnt   = nrounds_i ? P12_START : P6_START;
        end
      end
      ST_LOAD: begin
        w_state = ST_ROUND;
      end
      ST_ROUND: begin
        if (r_cnt == LAST_ROUND) begin
          w_state = ST_DONE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
      end
    endcase
    if (w_abort && ((r_state == ST_LOAD) || (r_state == ST_ROUND))) begin
      w_state = ST_IDLE;
      w_cnt   = '0;
    end
  end

  // State, counter and outputs are all registered from the next-state view
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_nr      <= 1'b0;
      r_load    <= 1'b0;
      r_perm_en <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_nr      <= w_nr;
      r_load    <= (w_state == ST_LOAD);
      r_perm_en <= (w_state == ST_ROUND);
      r_last    <= (w_state == ST_ROUND) && (w_cnt == LAST_ROUND);
      r_busy    <= (w_state != ST_IDLE);
      r_done    <= (w_state == ST_DONE);
    end
  end

  assign load_o    = r_load;
  assign perm_en_o = r_perm_en;
  assign round_o   = r_cnt;
  assign last_o    = r_last;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

  // Structural invariants of the schedule
  a_strobe_excl: assert property (@(posedge clock_i) disable iff (!resetb_i)
    $onehot0({r_load, r_perm_en, r_done}));
  a_cnt_range: assert property (@(posedge clock_i) disable iff (!resetb_i)
    r_cnt <= LAST_ROUND);

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed, table-driven bench for ascon_perm_sched (define ASCON_ABORT_EN to cover abort).
module tb_ascon_perm_sched;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic       nrounds_i;
`ifdef ASCON_ABORT_EN
  logic       abort_i;
`endif
  logic       load_o;
  logic       perm_en_o;
  logic [3:0] round_o;
  logic       last_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_errors = 0;

  ascon_perm_sched dut (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .start_i   (start_i),
    .nrounds_i (nrounds_i),
`ifdef ASCON_ABORT_EN
    .abort_i   (abort_i),
`endif
    .load_o    (load_o),
    .perm_en_o (perm_en_o),
    .round_o   (round_o),
    .last_o    (last_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       start;
    logic       nr;
    logic       ld;
    logic       pe;
    logic [3:0] rnd;
    logic       last;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic start, input logic nr, input logic ld,
                              input logic pe, input logic [3:0] rnd, input logic last,
                              input logic busy, input logic done);
    vec_t v;
    v.start = start; v.nr = nr; v.ld = ld; v.pe = pe;
    v.rnd = rnd; v.last = last; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic check_outs(input string name, input logic ld, input logic pe,
                            input logic [3:0] rnd, input logic last,
                            input logic busy, input logic done);
    logic [8:0] act;
    logic [8:0] exp;
    act = {load_o, perm_en_o, round_o, last_o, busy_o, done_o};
    exp = {ld, pe, rnd, last, busy, done};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {load,perm,round,last,busy,done}=%b_%b_%0d_%b_%b_%b want %b_%b_%0d_%b_%b_%b",
               name, load_o, perm_en_o, round_o, last_o, busy_o, done_o,
               ld, pe, rnd, last, busy, done);
    end
    n_checks++;
    if ((int'(load_o) + int'(perm_en_o) + int'(done_o)) > 1) begin
      n_errors++;
      $display("FAIL %s_excl: load=%b perm=%b done=%b, want at most one high",
               name, load_o, perm_en_o, done_o);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    resetb_i  = 1'b1;
    start_i   = 1'b0;
    nrounds_i = 1'b0;
`ifdef ASCON_ABORT_EN
    abort_i   = 1'b0;
`endif

    // p12 run with start/nrounds noise during the run
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 12; k++)
      vecs.push_back(mk((k % 3) == 0, (k % 2) == 1, 1'b0, 1'b1, 4'(k), k == 11, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    // start held through DONE: p6 begins after exactly one idle cycle
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0));
    for (int r = 6; r < 12; r++)
      vecs.push_back(mk(r == 8, (r % 2) == 0, 1'b0, 1'b1, 4'(r), r == 11, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

    // Power-up reset: outputs must be zero during and after reset
    #1 resetb_i = 1'b0;
    #1 check_outs("rst_async", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    nrounds_i = 1'b1;
    step();
    check_outs("rst_held", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b0;
    @(negedge clock_i);
    resetb_i = 1'b1;
    step();
    check_outs("post_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      start_i   = vecs[i].start;
      nrounds_i = vecs[i].nr;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].ld, vecs[i].pe, vecs[i].rnd,
                 vecs[i].last, vecs[i].busy, vecs[i].done);
    end

    // Back-to-back p6 with start held: done every 9 cycles, one idle cycle between
    start_i   = 1'b1;
    nrounds_i = 1'b0;
    for (int e = 0; e < 40; e++) begin
      step();
      check_bit($sformatf("b2b_done%0d", e), done_o, (e % 9) == 7);
      check_bit($sformatf("b2b_busy%0d", e), busy_o, (e % 9) != 8);
    end
    start_i = 1'b0;
    for (int e = 0; e < 12; e++) step();
    check_outs("b2b_drain", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at round 5 of p12
    start_i   = 1'b1;
    nrounds_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int e = 1; e <= 6; e++) step();
    check_outs("pre_rst_r5", 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
    #2 resetb_i = 1'b0;
    #1 check_outs("midrun_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) begin
      step();
      check_bit($sformatf("rst_nodone%0d", e), done_o, 1'b0);
    end
    @(negedge clock_i);
    resetb_i = 1'b1;
    step();
    check_outs("rst_idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    start_i   = 1'b1;
    nrounds_i = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      start_i = 1'b0;
      check_bit($sformatf("rst_p6_done%0d", e), done_o, e == 7);
      if (e == 0) check_outs("rst_p6_load", 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    end

`ifdef ASCON_ABORT_EN
    // Abort at round 3 of p12, then abort+start together in IDLE
    start_i   = 1'b1;
    nrounds_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    check_outs("abt_r3", 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    abort_i = 1'b1;
    step();
    check_outs("abt_idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    step();
    check_outs("abt_start_wins", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    abort_i = 1'b0;
    start_i = 1'b0;
    for (int e = 0; e < 14; e++) begin
      step();
      check_bit($sformatf("abt_run_done%0d", e), done_o, e == 12);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
